fetch_queue: RTL and testbench

Instruction fetch queue directly downstream of the instruction fetch manager. It absorbs `BUS_WID`-wide lines from the fetch manager and splits them into 16-bit parcels, so compressed and 32-bit instructions are both handled. It presents up to `FETCH_LEN` aligned instructions per cycle, each with its PC, to the decoder. It also drives `buffer_free` back to the fetch manager and flushes itself on every jump.

---
 rtl/fetch_queue.sv | 144 ++++++++++++++
 tb/tb_fetch_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: absorbs fetched lines, splits them into 16-bit parcels
// and presents up to FETCH_LEN aligned (16/32-bit) instructions with PCs to decode.
module fetch_queue #(
   parameter int XLEN      = 32,
   parameter int BUS_LEN   = 4,
   parameter int BUS_WID   = 32 * BUS_LEN,
   parameter int QUEUE_HW  = 32,
   parameter int FETCH_LEN = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          jump_vld,
   input  logic [XLEN-1:0]               jump_pc,
   input  logic                          line_vld,
   input  logic [BUS_WID-1:0]            line_data,
   output logic                          buffer_free,
   output logic [FETCH_LEN-1:0]          ins_vld,
   output logic [FETCH_LEN*32-1:0]       ins_data,
   output logic [FETCH_LEN*XLEN-1:0]     ins_pc,
   input  logic [$clog2(FETCH_LEN):0]    ins_acc
);

   localparam int PW      = $clog2(QUEUE_HW);
   localparam int CW      = PW + 1;
   localparam int LINE_HW = 2 * BUS_LEN;
   localparam int SKW     = $clog2(4 * BUS_LEN) - 1;
   localparam int AW      = $clog2(FETCH_LEN) + 1;

   logic [15:0]     mem_q [QUEUE_HW];
   logic [PW-1:0]   rp_q, rp_d, wp_q, wp_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] hpc_q, hpc_d;
   logic [SKW-1:0]  skip_q, skip_d;

   logic [CW-1:0]   freeCnt;
   logic [CW-1:0]   inParcels;
   logic [CW-1:0]   outParcels;
   logic [LINE_HW-1:0] wrEn;
   logic [PW-1:0]   wrIdx [LINE_HW];

   assign freeCnt     = CW'(QUEUE_HW) - cnt_q;
   assign buffer_free = freeCnt >= CW'(4 * BUS_LEN);

   // Slots are laid back-to-back from rp; a slot is valid only if every parcel it
   // needs is already inside cnt, which also keeps the valid mask a thermometer.
   always_comb begin : decodeComb
      logic [CW-1:0] slotOff [FETCH_LEN+1];
      logic [15:0]   lo;
      logic [15:0]   hi;
      logic          is32;
      logic          chainOk;
      logic [AW-1:0] nValid;
      logic [AW-1:0] accEff;
      ins_vld    = '0;
      ins_data   = '0;
      ins_pc     = '0;
      outParcels = '0;
      lo         = '0;
      hi         = '0;
      is32       = 1'b0;
      chainOk    = 1'b1;
      nValid     = '0;
      slotOff[0] = '0;
      for (int i = 0; i < FETCH_LEN; i++) begin
         lo   = mem_q[rp_q + PW'(slotOff[i])];
         hi   = mem_q[rp_q + PW'(slotOff[i]) + PW'(1)];
         is32 = (lo[1:0] == 2'b11);
         slotOff[i+1] = slotOff[i] + (is32 ? CW'(2) : CW'(1));
         if (chainOk && !jump_vld && (slotOff[i+1] <= cnt_q)) begin
            ins_vld[i] = 1'b1;
            nValid     = nValid + AW'(1);
         end else begin
            chainOk = 1'b0;
         end
         ins_data[i*32 +: 32]     = is32 ? {hi, lo} : {16'h0000, lo};
         ins_pc[i*XLEN +: XLEN]   = hpc_q + (XLEN'(slotOff[i]) << 1);
      end
      accEff = (ins_acc > nValid) ? nValid : ins_acc;
      for (int i = 0; i < FETCH_LEN; i++) begin
         if (AW'(i) < accEff) begin
            outParcels = slotOff[i+1];
         end
      end
   end

   always_comb begin : nextComb
      rp_d      = rp_q;
      wp_d      = wp_q;
      cnt_d     = cnt_q;
      hpc_d     = hpc_q;
      skip_d    = skip_q;
      wrEn      = '0;
      inParcels = '0;
      for (int j = 0; j < LINE_HW; j++) begin
         wrIdx[j] = wp_q + PW'(j) - PW'(skip_q);
      end
      if (jump_vld) begin
         rp_d   = '0;
         wp_d   = '0;
         cnt_d  = '0;
         hpc_d  = jump_pc;
         skip_d = jump_pc[SKW:1];
      end else begin
         // A line arriving without room is a protocol violation and is dropped whole.
         if (line_vld && (freeCnt >= CW'(LINE_HW))) begin
            inParcels = CW'(LINE_HW) - CW'(skip_q);
            skip_d    = '0;
            for (int j = 0; j < LINE_HW; j++) begin
               wrEn[j] = (CW'(j) >= CW'(skip_q));
            end
         end
         wp_d  = wp_q + PW'(inParcels);
         rp_d  = rp_q + PW'(outParcels);
         hpc_d = hpc_q + (XLEN'(outParcels) << 1);
         cnt_d = cnt_q + inParcels - outParcels;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rp_q   <= '0;
         wp_q   <= '0;
         cnt_q  <= '0;
         hpc_q  <= '0;
         skip_q <= '0;
      end else begin
         rp_q   <= rp_d;
         wp_q   <= wp_d;
         cnt_q  <= cnt_d;
         hpc_q  <= hpc_d;
         skip_q <= skip_d;
      end
   end

   // Parcel storage needs no reset: nothing is presented beyond cnt.
   always_ff @(posedge clk) begin
      for (int j = 0; j < LINE_HW; j++) begin
         if (wrEn[j]) begin
            mem_q[wrIdx[j]] <= line_data[16*j +: 16];
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: jumps, misaligned entry, split instructions,
// flow control, overflow drop, jump collision and asynchronous reset.
module tb_fetch_queue;

   localparam int XLEN      = 32;
   localparam int BUS_LEN   = 4;
   localparam int BUS_WID   = 128;
   localparam int QUEUE_HW  = 32;
   localparam int FETCH_LEN = 4;

   logic                      clk;
   logic                      rst;
   logic                      jump_vld;
   logic [XLEN-1:0]           jump_pc;
   logic                      line_vld;
   logic [BUS_WID-1:0]        line_data;
   logic                      buffer_free;
   logic [FETCH_LEN-1:0]      ins_vld;
   logic [FETCH_LEN*32-1:0]   ins_data;
   logic [FETCH_LEN*XLEN-1:0] ins_pc;
   logic [2:0]                ins_acc;

   int errors = 0;
   int checks = 0;

   fetch_queue #(
      .XLEN(XLEN), .BUS_LEN(BUS_LEN), .BUS_WID(BUS_WID),
      .QUEUE_HW(QUEUE_HW), .FETCH_LEN(FETCH_LEN)
   ) dut (
      .clk(clk), .rst(rst), .jump_vld(jump_vld), .jump_pc(jump_pc),
      .line_vld(line_vld), .line_data(line_data), .buffer_free(buffer_free),
      .ins_vld(ins_vld), .ins_data(ins_data), .ins_pc(ins_pc), .ins_acc(ins_acc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [127:0] line4(input logic [31:0] w0, w1, w2, w3);
      return {w3, w2, w1, w0};
   endfunction

   function automatic logic [31:0] tagNop(input int n, input int m);
      return {8'(n), 8'(m), 16'h0013};
   endfunction

   function automatic logic [31:0] slotData(input int i);
      return ins_data[i*32 +: 32];
   endfunction

   function automatic logic [31:0] slotPc(input int i);
      return ins_pc[i*XLEN +: XLEN];
   endfunction

   // Drive one cycle of inputs, pass the edge, then return inputs to idle.
   task automatic applyStimulus(input logic jv, input logic [31:0] jpc, input logic lv,
                                input logic [127:0] ld, input logic [2:0] acc);
      jump_vld  = jv;
      jump_pc   = jpc;
      line_vld  = lv;
      line_data = ld;
      ins_acc   = acc;
      @(posedge clk);
      #1;
      jump_vld  = 1'b0;
      jump_pc   = '0;
      line_vld  = 1'b0;
      line_data = '0;
      ins_acc   = '0;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [127:0] nopLine;

   initial begin
      nopLine   = line4(32'h13, 32'h13, 32'h13, 32'h13);
      rst       = 1'b1;
      jump_vld  = 1'b0;
      jump_pc   = '0;
      line_vld  = 1'b0;
      line_data = '0;
      ins_acc   = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_vld", ins_vld, 0);
      checkOutput("reset_free", buffer_free, 1);
      rst = 1'b0;

      $display("[TB] reset then jump");
      applyStimulus(1, 32'h200, 0, '0, 0);
      applyStimulus(0, 0, 1, nopLine, 0);
      checkOutput("t1_vld", ins_vld, 4'b1111);
      checkOutput("t1_pc0", slotPc(0), 32'h200);
      checkOutput("t1_pc1", slotPc(1), 32'h204);
      checkOutput("t1_pc2", slotPc(2), 32'h208);
      checkOutput("t1_pc3", slotPc(3), 32'h20C);
      checkOutput("t1_data0", slotData(0), 32'h13);
      checkOutput("t1_data3", slotData(3), 32'h13);
      applyStimulus(0, 0, 0, '0, 4);
      checkOutput("t1_vld_after", ins_vld, 0);
      checkOutput("t1_cnt_after", dut.cnt_q, 0);
      checkOutput("t1_hpc_after", dut.hpc_q, 32'h210);

      $display("[TB] misaligned jump");
      applyStimulus(1, 32'h20A, 0, '0, 0);
      applyStimulus(0, 0, 1, line4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hABCD_FFFF, 32'h1234_5677), 0);
      checkOutput("t2_vld", ins_vld, 4'b0011);
      checkOutput("t2_data0", slotData(0), 32'h0000ABCD);
      checkOutput("t2_pc0", slotPc(0), 32'h20A);
      checkOutput("t2_data1", slotData(1), 32'h12345677);
      checkOutput("t2_pc1", slotPc(1), 32'h20C);
      applyStimulus(0, 0, 0, '0, 2);
      checkOutput("t2_hpc_after", dut.hpc_q, 32'h210);

      $display("[TB] split instruction");
      applyStimulus(0, 0, 1, line4(32'hAAAA_0003, 32'hBBBB_0007, 32'hCCCC_000B, 32'h4443_0001), 0);
      checkOutput("t3_vld", ins_vld, 4'b1111);
      checkOutput("t3_data2", slotData(2), 32'hCCCC000B);
      checkOutput("t3_pc3", slotPc(3), 32'h21C);
      checkOutput("t3_data3", slotData(3), 32'h00000001);
      applyStimulus(0, 0, 0, '0, 4);
      checkOutput("t3_split_wait", ins_vld, 0);
      checkOutput("t3_split_pc", slotPc(0), 32'h21E);
      line_vld  = 1'b1;
      line_data = line4(32'h0002_6666, 32'h13, 32'h13, 32'h13);
      #1;
      checkOutput("t3_no_bypass", ins_vld, 0);
      applyStimulus(0, 0, 1, line4(32'h0002_6666, 32'h13, 32'h13, 32'h13), 0);
      checkOutput("t3_vld_b", ins_vld, 4'b1111);
      checkOutput("t3_split_data", slotData(0), 32'h66664443);
      checkOutput("t3_split_pc_b", slotPc(0), 32'h21E);
      checkOutput("t3_data1_b", slotData(1), 32'h00000002);
      checkOutput("t3_pc1_b", slotPc(1), 32'h222);
      checkOutput("t3_pc2_b", slotPc(2), 32'h224);
      checkOutput("t3_pc3_b", slotPc(3), 32'h228);
      applyStimulus(0, 0, 0, '0, 4);
      checkOutput("t3_tail_vld", ins_vld, 4'b0001);
      checkOutput("t3_tail_pc", slotPc(0), 32'h22C);
      applyStimulus(0, 0, 0, '0, 1);

      $display("[TB] flow control and wrap");
      for (int n = 1; n <= 4; n++) begin
         applyStimulus(0, 0, 1, line4(tagNop(n, 0), tagNop(n, 1), tagNop(n, 2), tagNop(n, 3)), 0);
         checkOutput($sformatf("t4_free_line%0d", n), buffer_free, (n <= 2) ? 1 : 0);
      end
      applyStimulus(0, 0, 1, line4(tagNop(5, 0), tagNop(5, 1), tagNop(5, 2), tagNop(5, 3)), 0);
      checkOutput("t4_overflow_cnt", dut.cnt_q, 32);
      checkOutput("t4_overflow_wp", dut.wp_q, 19);
      checkOutput("t4_vld", ins_vld, 4'b1111);
      checkOutput("t4_data0", slotData(0), tagNop(1, 0));
      checkOutput("t4_pc0", slotPc(0), 32'h230);
      checkOutput("t4_pc3", slotPc(3), 32'h23C);
      applyStimulus(0, 0, 0, '0, 4);
      checkOutput("t4_free_8", buffer_free, 0);
      checkOutput("t4_wrap_data0", slotData(0), tagNop(2, 0));
      checkOutput("t4_wrap_pc0", slotPc(0), 32'h240);
      checkOutput("t4_wrap_data2", slotData(2), tagNop(2, 2));
      checkOutput("t4_wrap_pc2", slotPc(2), 32'h248);
      applyStimulus(0, 0, 0, '0, 4);
      checkOutput("t4_free_16", buffer_free, 1);
      applyStimulus(0, 0, 0, '0, 4);
      checkOutput("t4_data_last", slotData(3), tagNop(4, 3));
      applyStimulus(0, 0, 0, '0, 4);
      checkOutput("t4_drained", ins_vld, 0);

      $display("[TB] jump collision");
      applyStimulus(0, 0, 1, nopLine, 0);
      jump_vld  = 1'b1;
      jump_pc   = 32'h400;
      line_vld  = 1'b1;
      line_data = line4(32'hDEAD_0003, 32'hDEAD_0003, 32'hDEAD_0003, 32'hDEAD_0003);
      ins_acc   = 3'd2;
      #1;
      checkOutput("t5_vld_jump", ins_vld, 0);
      applyStimulus(1, 32'h400, 1, line4(32'hDEAD_0003, 32'hDEAD_0003, 32'hDEAD_0003, 32'hDEAD_0003), 2);
      checkOutput("t5_cnt", dut.cnt_q, 0);
      checkOutput("t5_hpc", dut.hpc_q, 32'h400);
      applyStimulus(0, 0, 1, nopLine, 0);
      checkOutput("t5_pc0", slotPc(0), 32'h400);
      checkOutput("t5_data0", slotData(0), 32'h13);
      applyStimulus(0, 0, 0, '0, 4);

      $display("[TB] mixed stream and async reset");
      applyStimulus(0, 0, 1, line4(32'h0013_0001, 32'h0005_0000, 32'h8883_0009, 32'h0F03_7777), 0);
      checkOutput("t6_vld", ins_vld, 4'b1111);
      checkOutput("t6_pc1", slotPc(1), 32'h412);
      checkOutput("t6_data1", slotData(1), 32'h13);
      checkOutput("t6_pc3", slotPc(3), 32'h418);
      checkOutput("t6_data3", slotData(3), 32'h9);
      applyStimulus(0, 0, 0, '0, 3);
      checkOutput("t6_vld_b", ins_vld, 4'b0011);
      checkOutput("t6_pc1_b", slotPc(1), 32'h41A);
      checkOutput("t6_data1_b", slotData(1), 32'h77778883);
      applyStimulus(0, 0, 0, '0, 2);
      checkOutput("t6_split_wait", ins_vld, 0);
      applyStimulus(0, 0, 1, line4(32'h0011_0ABC, 32'h0, 32'h0, 32'h0), 0);
      checkOutput("t6_vld_c", ins_vld, 4'b1111);
      checkOutput("t6_split_data", slotData(0), 32'h0ABC0F03);
      checkOutput("t6_split_pc", slotPc(0), 32'h41E);
      checkOutput("t6_pc1_c", slotPc(1), 32'h422);
      checkOutput("t6_data1_c", slotData(1), 32'h11);
      rst = 1'b1;
      #1;
      checkOutput("t6_rst_vld", ins_vld, 0);
      checkOutput("t6_rst_free", buffer_free, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
